riscv_lsu: RTL

- Load/store unit between the single-cycle core's data-memory port and a wait-state data memory.
- Converts core requests (byte address, RISC-V size code, store data) into word-aligned bus transactions with byte enables and a req/ack handshake.
- Aligns and extends load data, and stalls the core until the access completes.
- Flags misaligned or illegal-size accesses and bus timeouts instead of issuing them.

---
 rtl/riscv_lsu.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between a single-cycle core's data port and a
// wait-state data memory.
//
// Turns a core request (byte address, funct3 size code, store data) into one
// word-aligned bus transaction with byte enables, held under a req/ack
// handshake. Load data is lane-selected and extended before it reaches the
// core. The core is stalled until the access retires. Misaligned or
// illegal-size requests are never issued to the bus; bus accesses that see
// no ack within TIMEOUT cycles are abandoned.
//
// Ports:
//   CLK, reset                 clock, asynchronous active-high reset
//   core_req_i / core_we_i     access request, 1 = store
//   core_size_i                funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
//   core_addr_i / core_wd_i    byte address, store data
//   core_rd_o                  formatted load data, valid in the retire cycle
//   core_stall_o               hold PC and suppress writeback
//   misaligned_o / bus_error_o one-cycle rejection / timeout pulses
//   mem_req_o .. mem_wd_o      bus request, write, byte enables, address, data
//   mem_rd_i / mem_ack_i       read word and completion strobe
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misaligned_o,
  output logic        bus_error_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StErr} state_e;

  // Last counter value before abort; unused when the timeout is disabled.
  localparam int unsigned TimeoutLast = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_e      state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic [31:0] rd_q;
  logic [31:0] cnt_q;
  logic        cause_bus_q;  // ERR cause: 1 = timeout, 0 = rejected request

  logic        legal;
  logic [3:0]  be_fmt;
  logic [31:0] wd_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic        timeout_hit;

  // Request legality.
  always_comb begin
    legal = 1'b0;
    case (core_size_i)
      3'd0:    legal = 1'b1;
      3'd1:    legal = ~core_addr_i[0];
      3'd2:    legal = (core_addr_i[1:0] == 2'b00);
      3'd4:    legal = ~core_we_i;
      3'd5:    legal = ~core_we_i & ~core_addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  // Store formatting; loads always enable the whole word.
  always_comb begin
    be_fmt = 4'b1111;
    wd_fmt = core_wd_i;
    if (core_we_i) begin
      case (core_size_i)
        3'd0: begin
          be_fmt = 4'b0001 << core_addr_i[1:0];
          wd_fmt = {4{core_wd_i[7:0]}};
        end
        3'd1: begin
          be_fmt = core_addr_i[1] ? 4'b1100 : 4'b0011;
          wd_fmt = {2{core_wd_i[15:0]}};
        end
        default: begin
          be_fmt = 4'b1111;
          wd_fmt = core_wd_i;
        end
      endcase
    end
  end

  // Load lane selection and extension.
  always_comb begin
    ld_byte = mem_rd_i[7:0];
    case (off_q)
      2'd0: ld_byte = mem_rd_i[7:0];
      2'd1: ld_byte = mem_rd_i[15:8];
      2'd2: ld_byte = mem_rd_i[23:16];
      2'd3: ld_byte = mem_rd_i[31:24];
      default: ld_byte = mem_rd_i[7:0];
    endcase
    ld_half = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q)
      3'd0:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_fmt = {24'b0, ld_byte};
      3'd5:    ld_fmt = {16'b0, ld_half};
      default: ld_fmt = mem_rd_i;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);

  // FSM state register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (core_req_i) begin
          state_d = legal ? StBusy : StErr;
        end
      end
      StBusy: begin
        if (mem_ack_i) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture, wait counter and load-data latch.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      we_q        <= 1'b0;
      addr_q      <= 32'b0;
      be_q        <= 4'b0;
      wd_q        <= 32'b0;
      off_q       <= 2'b0;
      size_q      <= 3'b0;
      rd_q        <= 32'b0;
      cnt_q       <= 32'b0;
      cause_bus_q <= 1'b0;
    end else begin
      if (state_q == StIdle && core_req_i) begin
        we_q        <= core_we_i;
        addr_q      <= {core_addr_i[31:2], 2'b00};
        be_q        <= be_fmt;
        wd_q        <= wd_fmt;
        off_q       <= core_addr_i[1:0];
        size_q      <= core_size_i;
        cnt_q       <= 32'b0;
        cause_bus_q <= 1'b0;
      end
      if (state_q == StBusy) begin
        cnt_q <= cnt_q + 32'd1;
        if (mem_ack_i) begin
          rd_q <= we_q ? 32'b0 : ld_fmt;
        end else if (timeout_hit) begin
          cause_bus_q <= 1'b1;
        end
      end
    end
  end

  // Outputs: bus signals only live in BUSY so reset clears them at once.
  always_comb begin
    mem_req_o    = (state_q == StBusy);
    mem_we_o     = mem_req_o & we_q;
    mem_be_o     = mem_req_o ? be_q : 4'b0;
    mem_addr_o   = mem_req_o ? addr_q : 32'b0;
    mem_wd_o     = mem_req_o ? wd_q : 32'b0;
    core_rd_o    = (state_q == StDone) ? rd_q : 32'b0;
    misaligned_o = (state_q == StErr) & ~cause_bus_q;
    bus_error_o  = (state_q == StErr) & cause_bus_q;
    core_stall_o = core_req_i & ((state_q == StIdle) | (state_q == StBusy));
  end

endmodule
